// File: rtl/mmu_tlb.sv
// Fully-associative micro-TLB in front of the MMU table walker: hits answered from cached
// section/page entries, misses walked and filled round-robin. Optional flush: MMU_TLB_FLUSH_EN.
module mmu_tlb #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_req_valid,
    input  logic [31:0] in_mva,
    output logic        out_req_ready,
    output logic        out_resp_valid,
    output logic [31:0] out_pa,
    output logic        out_fault,
    output logic        out_walk_req,
    output logic [31:0] out_walk_mva,
    input  logic        in_walk_done,
    input  logic        in_walk_fault,
    input  logic        in_walk_section,
    input  logic [19:0] in_walk_pa,
`ifdef MMU_TLB_FLUSH_EN
    input  logic        in_flush,
`endif
    output logic [1:0]  out_dbg_state
);

    // Handshake: a request transfers on a rising edge where in_req_valid && out_req_ready;
    // out_req_ready is only high in IDLE, so at most one translation is outstanding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WALK   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [31:0]       mva_q;
    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_sect;
    logic [19:0]       ent_vtag  [ENTRIES];
    logic [19:0]       ent_pbase [ENTRIES];
    logic [IDX_W-1:0]  victim;
    logic              walk_flushed;
    logic              flush;
    logic              hit;
    logic [31:0]       hit_pa;
    logic [31:0]       walk_pa;

`ifdef MMU_TLB_FLUSH_EN
    assign flush = in_flush;
`else
    assign flush = 1'b0;
`endif

    assign out_dbg_state = state;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hit_pa = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_sect[i] ? (ent_vtag[i][19:8] == mva_q[31:20])
                                             : (ent_vtag[i] == mva_q[31:12]))) begin
                hit    = 1'b1;
                hit_pa = ent_sect[i] ? {ent_pbase[i][19:8], mva_q[19:0]}
                                     : {ent_pbase[i], mva_q[11:0]};
            end
        end
    end

    assign walk_pa = in_walk_section ? {in_walk_pa[19:8], mva_q[19:0]}
                                     : {in_walk_pa, mva_q[11:0]};

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state          <= IDLE;
            mva_q          <= '0;
            ent_valid      <= '0;
            ent_sect       <= '0;
            victim         <= '0;
            walk_flushed   <= 1'b0;
            out_req_ready  <= 1'b0;
            out_resp_valid <= 1'b0;
            out_pa         <= '0;
            out_fault      <= 1'b0;
            out_walk_req   <= 1'b0;
            out_walk_mva   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_req_ready && in_req_valid) begin
                        mva_q         <= in_mva;
                        out_req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end else begin
                        out_req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit && !flush) begin
                        out_pa         <= hit_pa;
                        out_resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        out_walk_req <= 1'b1;
                        out_walk_mva <= mva_q;
                        walk_flushed <= 1'b0;
                        state        <= WALK;
                    end
                end
                WALK: begin
                    if (flush) begin
                        walk_flushed <= 1'b1;
                    end
                    if (in_walk_done) begin
                        out_walk_req   <= 1'b0;
                        out_resp_valid <= 1'b1;
                        state          <= RESP;
                        if (in_walk_fault) begin
                            out_fault <= 1'b1;
                            out_pa    <= '0;
                        end else begin
                            out_pa <= walk_pa;
                            // A flush seen at any point of this walk makes its result stale.
                            if (!walk_flushed && !flush) begin
                                ent_valid[victim] <= 1'b1;
                                ent_sect[victim]  <= in_walk_section;
                                ent_vtag[victim]  <= mva_q[31:12];
                                ent_pbase[victim] <= in_walk_pa;
                                if (victim == IDX_W'(ENTRIES - 1)) begin
                                    victim <= '0;
                                end else begin
                                    victim <= victim + IDX_W'(1);
                                end
                            end
                        end
                    end
                end
                RESP: begin
                    out_resp_valid <= 1'b0;
                    out_fault      <= 1'b0;
                    out_req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (flush) begin
                ent_valid <= '0;
                victim    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed scenarios plus randomized traffic against a
// behavioural TLB model (flush scenarios compiled when MMU_TLB_FLUSH_EN is defined).
module tb_mmu_tlb;
    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;

    logic        in_clk = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_req_valid = 1'b0;
    logic [31:0] in_mva = '0;
    logic        out_req_ready, out_resp_valid, out_fault, out_walk_req;
    logic [31:0] out_pa, out_walk_mva;
    logic        in_walk_done = 1'b0, in_walk_fault = 1'b0, in_walk_section = 1'b0;
    logic [19:0] in_walk_pa = '0;
    logic [1:0]  dbg_state;
`ifdef MMU_TLB_FLUSH_EN
    logic        in_flush = 1'b0;
`endif

    mmu_tlb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req_valid(in_req_valid), .in_mva(in_mva),
        .out_req_ready(out_req_ready), .out_resp_valid(out_resp_valid), .out_pa(out_pa),
        .out_fault(out_fault), .out_walk_req(out_walk_req), .out_walk_mva(out_walk_mva),
        .in_walk_done(in_walk_done), .in_walk_fault(in_walk_fault),
        .in_walk_section(in_walk_section), .in_walk_pa(in_walk_pa),
`ifdef MMU_TLB_FLUSH_EN
        .in_flush(in_flush),
`endif
        .out_dbg_state(dbg_state)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    // Reference model: a list of cached translations replaced in strict rotation.
    bit          m_valid [ENTRIES];
    bit          m_sect  [ENTRIES];
    logic [19:0] m_vtag  [ENTRIES];
    logic [19:0] m_pbase [ENTRIES];
    int          m_ptr;

    bit          r_walked, r_ws, r_po, r_fault;
    logic [31:0] r_wmva, r_pa;
    int          r_lat;

    function automatic void model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic logic [31:0] form_pa(input logic [31:0] mva, input bit sect, input logic [19:0] base);
        logic [31:0] a;
        if (sect) a = ({12'h0, base[19:8]} << 20) + (mva % 32'h0010_0000);
        else      a = ({12'h0, base} << 12) + (mva % 32'h0000_1000);
        return a;
    endfunction

    function automatic bit model_lookup(input logic [31:0] mva, output logic [31:0] pa);
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i]) begin
                if (m_sect[i] ? ((m_vtag[i] >> 8) == (mva >> 20)) : (m_vtag[i] == (mva >> 12))) begin
                    pa = form_pa(mva, m_sect[i], m_pbase[i]);
                    return 1'b1;
                end
            end
        end
        pa = '0;
        return 1'b0;
    endfunction

    function automatic void model_fill(input logic [31:0] mva, input bit sect, input logic [19:0] base);
        m_valid[m_ptr] = 1'b1;
        m_sect[m_ptr]  = sect;
        m_vtag[m_ptr]  = 20'(mva >> 12);
        m_pbase[m_ptr] = base;
        m_ptr = (m_ptr + 1) % ENTRIES;
    endfunction

    // Driver: one full translation; returns what the DUT did. Sampling is 1ns after posedge.
    task automatic translate(input logic [31:0] mva, input bit w_fault, input bit w_sect,
                             input logic [19:0] w_pa, input int w_delay, input bit flush_walk);
        logic [31:0] mpa;
        bit mhit, flushed;
        int t;
        mhit = model_lookup(mva, mpa);
        flushed = 1'b0;
        r_walked = 1'b0; r_wmva = '0; r_pa = '0; r_fault = 1'b0; r_lat = 99; r_ws = 1'b1; r_po = 1'b0;
        t = 0;
        while (!out_req_ready && t < 50) begin @(posedge in_clk); #1; t++; end
        in_req_valid = 1'b1; in_mva = mva;
        @(posedge in_clk); #1;
        in_req_valid = 1'b0; in_mva = $urandom();
        t = 0;
        while (!out_resp_valid && !out_walk_req && t < 20) begin @(posedge in_clk); #1; t++; end
        if (out_walk_req) begin
            r_walked = 1'b1; r_wmva = out_walk_mva;
            if (flush_walk) begin
`ifdef MMU_TLB_FLUSH_EN
                in_flush = 1'b1; @(posedge in_clk); #1; in_flush = 1'b0;
                model_clear(); flushed = 1'b1;
`endif
            end
            repeat (w_delay) begin
                @(posedge in_clk); #1;
                if (out_walk_req !== 1'b1 || out_walk_mva !== r_wmva) r_ws = 1'b0;
            end
            in_walk_done = 1'b1; in_walk_fault = w_fault; in_walk_section = w_sect; in_walk_pa = w_pa;
            @(posedge in_clk); #1;
            in_walk_done = 1'b0; in_walk_fault = 1'($urandom()); in_walk_pa = 20'($urandom());
            if (out_walk_req !== 1'b0) r_ws = 1'b0;
            t = 1;
            while (!out_resp_valid && t < 20) begin @(posedge in_clk); #1; t++; end
        end
        if (out_resp_valid) begin r_lat = t; r_pa = out_pa; r_fault = out_fault; end
        @(posedge in_clk); #1;
        r_po = (out_resp_valid === 1'b0 && out_fault === 1'b0 && out_req_ready === 1'b1);
        if (!mhit && !w_fault && !flushed) model_fill(mva, w_sect, w_pa);
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        n_checks++; if (out_req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", out_req_ready); else n_pass++;
        n_checks++; if (out_resp_valid !== 1'b0 || out_fault !== 1'b0) $display("FAIL reset_resp: got %b/%b want 0/0", out_resp_valid, out_fault); else n_pass++;
        n_checks++; if (out_pa !== 32'h0) $display("FAIL reset_pa: got %h want 0", out_pa); else n_pass++;
        n_checks++; if (out_walk_req !== 1'b0 || out_walk_mva !== 32'h0) $display("FAIL reset_walk: got %b/%h want 0/0", out_walk_req, out_walk_mva); else n_pass++;
        in_rst_n = 1'b1;
        n_checks++; if (out_req_ready !== 1'b0) $display("FAIL ready_early: got %b want 0", out_req_ready); else n_pass++;
        @(posedge in_clk); #1;
        n_checks++; if (out_req_ready !== 1'b1) $display("FAIL ready_rise: got %b want 1", out_req_ready); else n_pass++;
        model_clear();
    endtask

    task automatic test_section();
        translate(32'h0010_0123, 1'b0, 1'b1, 20'h80100, 1, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_wmva !== 32'h0010_0123) $display("FAIL sec_walk: got %b/%h want 1/00100123", r_walked, r_wmva); else n_pass++;
        n_checks++; if (r_pa !== 32'h8010_0123 || r_fault !== 1'b0) $display("FAIL sec_pa: got %h/%b want 80100123/0", r_pa, r_fault); else n_pass++;
        n_checks++; if (r_lat !== 1 || r_ws !== 1'b1 || r_po !== 1'b1) $display("FAIL sec_timing: got lat %0d stable %b pulse %b want 1 1 1", r_lat, r_ws, r_po); else n_pass++;
        translate(32'h001F_FFFC, 1'b0, 1'b0, 20'h0, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b0) $display("FAIL sec_hit_walk: got %b want 0", r_walked); else n_pass++;
        n_checks++; if (r_pa !== 32'h801F_FFFC || r_lat !== 1) $display("FAIL sec_hit: got %h lat %0d want 801ffffc lat 1", r_pa, r_lat); else n_pass++;
    endtask

    task automatic test_page();
        translate(32'h0040_2ABC, 1'b0, 1'b0, 20'h12345, 2, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_pa !== 32'h1234_5ABC) $display("FAIL page_miss: got %b/%h want 1/12345abc", r_walked, r_pa); else n_pass++;
        n_checks++; if (r_ws !== 1'b1) $display("FAIL page_walk_hold: got %b want 1", r_ws); else n_pass++;
        translate(32'h0040_2001, 1'b0, 1'b0, 20'h0, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b0 || r_pa !== 32'h1234_5001) $display("FAIL page_hit: got %b/%h want 0/12345001", r_walked, r_pa); else n_pass++;
        translate(32'h0040_3ABC, 1'b0, 1'b0, 20'h0ABCD, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_pa !== 32'h0ABC_DABC) $display("FAIL page_neighbour: got %b/%h want 1/0abcdabc", r_walked, r_pa); else n_pass++;
    endtask

    task automatic test_fault();
        translate(32'h0050_0040, 1'b1, 1'b0, 20'h11111, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_fault !== 1'b1 || r_pa !== 32'h0) $display("FAIL fault_resp: got %b/%b/%h want 1/1/0", r_walked, r_fault, r_pa); else n_pass++;
        n_checks++; if (r_po !== 1'b1) $display("FAIL fault_clear: got %b want 1", r_po); else n_pass++;
        translate(32'h0050_0040, 1'b0, 1'b0, 20'h22222, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_fault !== 1'b0 || r_pa !== 32'h2222_2040) $display("FAIL fault_not_cached: got %b/%b/%h want 1/0/22222040", r_walked, r_fault, r_pa); else n_pass++;
    endtask

    task automatic test_eviction();
        int walks;
        in_rst_n = 1'b0; @(posedge in_clk); #1; in_rst_n = 1'b1; model_clear();
        walks = 0;
        for (int i = 0; i <= ENTRIES; i++) begin
            translate(32'h1000_0000 + (i << 12), 1'b0, 1'b0, 20'h20000 + 20'(i), 0, 1'b0);
            walks += int'(r_walked);
        end
        n_checks++; if (walks !== ENTRIES + 1) $display("FAIL evict_fills: got %0d want %0d", walks, ENTRIES + 1); else n_pass++;
        translate(32'h1000_1123, 1'b0, 1'b0, 20'h0, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b0 || r_pa !== 32'h2000_1123) $display("FAIL evict_keep1: got %b/%h want 0/20001123", r_walked, r_pa); else n_pass++;
        translate(32'h1000_8456, 1'b0, 1'b0, 20'h0, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b0 || r_pa !== 32'h2000_8456) $display("FAIL evict_keep8: got %b/%h want 0/20008456", r_walked, r_pa); else n_pass++;
        translate(32'h1000_0789, 1'b0, 1'b0, 20'h30000, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_pa !== 32'h3000_0789) $display("FAIL evict_lost0: got %b/%h want 1/30000789", r_walked, r_pa); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int t;
        in_req_valid = 1'b1; in_mva = 32'h3000_0000;
        @(posedge in_clk); #1; in_req_valid = 1'b0;
        t = 0;
        while (!out_walk_req && t < 20) begin @(posedge in_clk); #1; t++; end
        n_checks++; if (out_walk_req !== 1'b1) $display("FAIL abort_walk_start: got %b want 1", out_walk_req); else n_pass++;
        in_rst_n = 1'b0; @(posedge in_clk); #1;
        n_checks++; if (out_walk_req !== 1'b0 || out_req_ready !== 1'b0) $display("FAIL abort_reset: got %b/%b want 0/0", out_walk_req, out_req_ready); else n_pass++;
        in_rst_n = 1'b1; model_clear();
        translate(32'h1000_1123, 1'b0, 1'b0, 20'h40001, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_pa !== 32'h4000_1123) $display("FAIL abort_cleared: got %b/%h want 1/40001123", r_walked, r_pa); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] mva, mpa, exp_pa;
        logic [19:0] w_pa;
        bit hit, w_sect, w_fault;
        for (int n = 0; n < 80; n++) begin
            mva = {12'h400 + 12'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 12'($urandom())};
            w_sect = ($urandom_range(0, 3) == 0);
            w_fault = ($urandom_range(0, 7) == 0);
            w_pa = 20'($urandom());
            hit = model_lookup(mva, mpa);
            exp_pa = hit ? mpa : (w_fault ? 32'h0 : form_pa(mva, w_sect, w_pa));
            exp_q.push_back(exp_pa);
            translate(mva, w_fault, w_sect, w_pa, $urandom_range(0, 3), 1'b0);
            exp_pa = exp_q.pop_front();
            n_checks++; if (r_walked !== !hit) $display("FAIL rnd_walk %0d: mva %h got %b want %b", n, mva, r_walked, !hit); else n_pass++;
            n_checks++; if (r_pa !== exp_pa) $display("FAIL rnd_pa %0d: mva %h got %h want %h", n, mva, r_pa, exp_pa); else n_pass++;
            n_checks++; if (r_fault !== (!hit && w_fault)) $display("FAIL rnd_fault %0d: got %b want %b", n, r_fault, !hit && w_fault); else n_pass++;
            n_checks++; if (r_lat !== 1 || r_po !== 1'b1) $display("FAIL rnd_timing %0d: got lat %0d pulse %b want 1 1", n, r_lat, r_po); else n_pass++;
            if ($urandom_range(0, 4) == 0) begin
                in_walk_done = 1'b1; in_walk_fault = 1'b0; in_walk_pa = 20'($urandom());
                @(posedge in_clk); #1; in_walk_done = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(posedge in_clk);
            #1;
        end
    endtask

`ifdef MMU_TLB_FLUSH_EN
    task automatic test_flush();
        in_rst_n = 1'b0; @(posedge in_clk); #1; in_rst_n = 1'b1; model_clear();
        translate(32'h0600_1000, 1'b0, 1'b0, 20'h61000, 0, 1'b0);
        translate(32'h0700_0000, 1'b0, 1'b1, 20'h70000, 0, 1'b0);
        in_flush = 1'b1; @(posedge in_clk); #1; in_flush = 1'b0; model_clear();
        translate(32'h0600_1010, 1'b0, 1'b0, 20'h61000, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1) $display("FAIL flush_a: got %b want 1", r_walked); else n_pass++;
        translate(32'h0705_0000, 1'b0, 1'b1, 20'h70000, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1) $display("FAIL flush_b: got %b want 1", r_walked); else n_pass++;
        translate(32'h0800_2345, 1'b0, 1'b0, 20'h88888, 1, 1'b1);
        n_checks++; if (r_walked !== 1'b1 || r_pa !== 32'h8888_8345 || r_fault !== 1'b0) $display("FAIL flush_walk_resp: got %b/%h/%b want 1/88888345/0", r_walked, r_pa, r_fault); else n_pass++;
        translate(32'h0800_2345, 1'b0, 1'b0, 20'h99999, 0, 1'b0);
        n_checks++; if (r_walked !== 1'b1 || r_pa !== 32'h9999_9345) $display("FAIL flush_walk_nofill: got %b/%h want 1/99999345", r_walked, r_pa); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_section();
        test_page();
        test_fault();
        test_eviction();
        test_reset_abort();
        test_random();
`ifdef MMU_TLB_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
